// File: rtl/rot_pkg.sv
// rot_pkg
// Shared definitions for the rotate/field-extract sequencer:
//   - default datapath width and amount-field width
//   - FSM state encoding
//   - 2-bit step-select coding of the 4-way select stage
//   - helper that converts a (amount, direction) pair into a left-rotate amount
package rot_pkg;

  localparam int unsigned ROT_WIDTH = 32;
  localparam int unsigned ROT_AMT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MASK  = 2'd2,
    DONE  = 2'd3
  } rot_state_e;

  localparam logic [1:0] SEL_PASS = 2'b00;
  localparam logic [1:0] SEL_1    = 2'b01;
  localparam logic [1:0] SEL_2    = 2'b10;
  localparam logic [1:0] SEL_3    = 2'b11;

  // A right rotate by N is a left rotate by (width - N) mod width.
  // width is a power of two, so the modulo is a simple mask.
  function automatic int unsigned eff_left_amount(input int unsigned amt,
                                                  input logic        dir,
                                                  input int unsigned width);
    if (dir) begin
      return (width - amt) & (width - 1);
    end
    return amt & (width - 1);
  endfunction

endpackage

// File: rtl/rot_step.sv
// rot_step
// Word-wide single step of the rotate path: rotate-left by 0..3 bits under a
// 2-bit select (00 pass, 01 by 1, 10 by 2, 11 by 3). Purely combinational.
// Ports:
//   data_i [WIDTH-1:0]  operand
//   sel_i  [1:0]        step select
//   data_o [WIDTH-1:0]  rotated operand
module rot_step
  import rot_pkg::*;
#(
  parameter int unsigned WIDTH = ROT_WIDTH
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       sel_i,
  output logic [WIDTH-1:0] data_o
);

  // 4-way select between the pass-through and the three rotated copies
  always_comb begin
    data_o = data_i;
    case (sel_i)
      SEL_1:   data_o = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
      SEL_2:   data_o = {data_i[WIDTH-3:0], data_i[WIDTH-1:WIDTH-2]};
      SEL_3:   data_o = {data_i[WIDTH-4:0], data_i[WIDTH-1:WIDTH-3]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/rot_sequencer.sv
// rot_sequencer
// Multi-cycle rotate/field-extract engine. An N-bit rotate is built from
// repeated 0..3-bit steps of one rot_step stage, optionally followed by a
// one-cycle low-order mask (LDB-style extract).
// Ports:
//   CLK, RESET_N                clock, async active-low reset
//   REQ_VALID/REQ_READY         request handshake
//   REQ_DATA, REQ_AMT, REQ_DIR  operand, rotate amount, 0=left 1=right
//   REQ_MASK_EN, REQ_MASK_LEN   keep bits [REQ_MASK_LEN:0] after rotating
//   RSP_VALID/RSP_READY         response handshake
//   RSP_DATA                    result word (held while RSP_VALID)
//   BUSY                        high in every state except IDLE
//   STEP_SEL                    select applied by the step stage this cycle
module rot_sequencer
  import rot_pkg::*;
#(
  parameter int unsigned WIDTH = ROT_WIDTH,
  parameter int unsigned AMT_W = ROT_AMT_W
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [WIDTH-1:0] REQ_DATA,
  input  logic [AMT_W-1:0] REQ_AMT,
  input  logic             REQ_DIR,
  input  logic             REQ_MASK_EN,
  input  logic [AMT_W-1:0] REQ_MASK_LEN,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [WIDTH-1:0] RSP_DATA,
  output logic             BUSY,
  output logic [1:0]       STEP_SEL
);

  rot_state_e       state_q,    state_d;
  logic [WIDTH-1:0] data_q,     data_d;
  logic [AMT_W-1:0] rem_q,      rem_d;
  logic             mask_en_q,  mask_en_d;
  logic [AMT_W-1:0] mask_len_q, mask_len_d;

  logic [AMT_W-1:0] eff_amt;
  logic [1:0]       step;
  logic [AMT_W-1:0] rem_after;
  logic [AMT_W-1:0] mask_shift;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] step_out;

  rot_step #(.WIDTH(WIDTH)) u_step (
    .data_i (data_q),
    .sel_i  (STEP_SEL),
    .data_o (step_out)
  );

  // Datapath helpers. The mask is built by shifting an all-ones word right,
  // so mask_len = WIDTH-1 gives all ones without an overflowing 2^WIDTH term.
  always_comb begin
    eff_amt    = AMT_W'(eff_left_amount(32'(REQ_AMT), REQ_DIR, WIDTH));
    step       = (rem_q >= AMT_W'(3)) ? SEL_3 : rem_q[1:0];
    rem_after  = rem_q - AMT_W'(step);
    mask_shift = AMT_W'(WIDTH - 1) - mask_len_q;
    mask       = {WIDTH{1'b1}} >> mask_shift;
  end

  // Next-state, datapath update and handshake outputs
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    rem_d      = rem_q;
    mask_en_d  = mask_en_q;
    mask_len_d = mask_len_q;
    REQ_READY  = 1'b0;
    RSP_VALID  = 1'b0;
    RSP_DATA   = '0;
    STEP_SEL   = SEL_PASS;

    case (state_q)
      IDLE: begin
        REQ_READY = 1'b1;
        if (REQ_VALID) begin
          data_d     = REQ_DATA;
          mask_en_d  = REQ_MASK_EN;
          mask_len_d = REQ_MASK_LEN;
          rem_d      = eff_amt;
          if (eff_amt != '0) begin
            state_d = SHIFT;
          end else if (REQ_MASK_EN) begin
            state_d = MASK;
          end else begin
            state_d = DONE;
          end
        end
      end

      SHIFT: begin
        STEP_SEL = step;
        data_d   = step_out;
        rem_d    = rem_after;
        if (rem_after == '0) begin
          state_d = mask_en_q ? MASK : DONE;
        end
      end

      MASK: begin
        data_d  = data_q & mask;
        state_d = DONE;
      end

      DONE: begin
        RSP_VALID = 1'b1;
        RSP_DATA  = data_q;
        if (RSP_READY) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign BUSY = (state_q != IDLE);

  // State and datapath registers; reset discards any operation in flight
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      data_q     <= '0;
      rem_q      <= '0;
      mask_en_q  <= 1'b0;
      mask_len_q <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      rem_q      <= rem_d;
      mask_en_q  <= mask_en_d;
      mask_len_q <= mask_len_d;
    end
  end

endmodule

// File: tb/tb_rot_sequencer.sv
// tb_rot_sequencer
// Self-checking bench for rot_sequencer: directed vector table, hand-written
// backpressure / reset / idle sequences, and randomized operations checked
// against a word-level reference model.
module tb_rot_sequencer;

  logic        CLK;
  logic        RESET_N;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [31:0] REQ_DATA;
  logic [4:0]  REQ_AMT;
  logic        REQ_DIR;
  logic        REQ_MASK_EN;
  logic [4:0]  REQ_MASK_LEN;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_DATA;
  logic        BUSY;
  logic [1:0]  STEP_SEL;

  int nChecks;
  int nFails;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  amt;
    logic        dir;
    logic        maskEn;
    logic [4:0]  maskLen;
    logic [31:0] expData;
    int          expLat;
  } vec_t;

  vec_t vecs[9];

  rot_sequencer #(.WIDTH(32), .AMT_W(5)) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .REQ_VALID    (REQ_VALID),
    .REQ_READY    (REQ_READY),
    .REQ_DATA     (REQ_DATA),
    .REQ_AMT      (REQ_AMT),
    .REQ_DIR      (REQ_DIR),
    .REQ_MASK_EN  (REQ_MASK_EN),
    .REQ_MASK_LEN (REQ_MASK_LEN),
    .RSP_VALID    (RSP_VALID),
    .RSP_READY    (RSP_READY),
    .RSP_DATA     (RSP_DATA),
    .BUSY         (BUSY),
    .STEP_SEL     (STEP_SEL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: left amount from direction, rotate via a doubled word,
  // then keep the low (maskLen+1) bits.
  function automatic int refEff(input logic [4:0] amt, input logic dir);
    if (dir) return (32 - int'(amt)) % 32;
    return int'(amt);
  endfunction

  function automatic logic [31:0] refResult(input logic [31:0] d, input logic [4:0] amt,
                                            input logic dir, input logic me,
                                            input logic [4:0] ml);
    logic [63:0] dbl;
    logic [63:0] m;
    logic [31:0] r;
    dbl = {d, d} << refEff(amt, dir);
    r   = dbl[63:32];
    if (me) begin
      m = (64'd1 << (int'(ml) + 1)) - 64'd1;
      r = r & m[31:0];
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Runs one full operation: presents the request, measures edges from the
  // accepting edge (counted as 1) to RSP_VALID, records SHIFT-cycle selects,
  // waits readyDelay cycles of backpressure, then completes the handshake.
  task automatic applyStimulus(input logic [31:0] d, input logic [4:0] amt, input logic dir,
                               input logic me, input logic [4:0] ml, input int readyDelay,
                               output logic [31:0] gotData, output int gotLat,
                               output int gotShifts, output logic [1:0] firstSel,
                               output logic [1:0] secondSel, output bit timedOut);
    int guard;
    gotData = '0; gotLat = 0; gotShifts = 0;
    firstSel = 2'b00; secondSel = 2'b00; timedOut = 1'b0;
    @(negedge CLK);
    REQ_DATA = d; REQ_AMT = amt; REQ_DIR = dir;
    REQ_MASK_EN = me; REQ_MASK_LEN = ml; REQ_VALID = 1'b1;
    guard = 0;
    while (!REQ_READY && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    if (!REQ_READY) begin
      timedOut = 1'b1;
      REQ_VALID = 1'b0;
      return;
    end
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
    gotLat = 1;
    guard = 0;
    @(negedge CLK);
    while (!RSP_VALID && guard < 40) begin
      if (STEP_SEL != 2'b00) begin
        if (gotShifts == 0) firstSel = STEP_SEL;
        else if (gotShifts == 1) secondSel = STEP_SEL;
        gotShifts++;
      end
      @(negedge CLK);
      gotLat++;
      guard++;
    end
    if (!RSP_VALID) begin
      timedOut = 1'b1;
      return;
    end
    gotData = RSP_DATA;
    repeat (readyDelay) @(negedge CLK);
    RSP_READY = 1'b1;
    @(posedge CLK);
    #1 RSP_READY = 1'b0;
  endtask

  initial begin
    logic [31:0] gotData;
    int          gotLat;
    int          gotShifts;
    logic [1:0]  s0, s1;
    bit          tmo;
    bit          stableOk;
    bit          sawValid;
    bit          readyOk;
    logic [31:0] rd;
    logic [4:0]  ra, rml;
    logic        rdir, rme;
    int          e;

    nChecks = 0;
    nFails  = 0;

    vecs[0] = '{32'h80000001, 5'd4,  1'b0, 1'b0, 5'd0,  32'h00000018, 3};
    vecs[1] = '{32'h00000001, 5'd1,  1'b1, 1'b0, 5'd0,  32'h80000000, 12};
    vecs[2] = '{32'h12345678, 5'd24, 1'b1, 1'b1, 5'd7,  32'h00000012, 5};
    vecs[3] = '{32'hDEADBEEF, 5'd0,  1'b0, 1'b1, 5'd31, 32'hDEADBEEF, 2};
    vecs[4] = '{32'hA5A5A5A5, 5'd0,  1'b1, 1'b0, 5'd0,  32'hA5A5A5A5, 1};
    vecs[5] = '{32'h00000003, 5'd31, 1'b0, 1'b0, 5'd0,  32'h80000001, 12};
    vecs[6] = '{32'hFFFFFFFF, 5'd5,  1'b0, 1'b1, 5'd0,  32'h00000001, 4};
    vecs[7] = '{32'h12345678, 5'd16, 1'b1, 1'b1, 5'd15, 32'h00001234, 8};
    vecs[8] = '{32'h0000000F, 5'd3,  1'b0, 1'b0, 5'd0,  32'h00000078, 2};

    RESET_N = 1'b0; REQ_VALID = 1'b0; REQ_DATA = '0; REQ_AMT = '0; REQ_DIR = 1'b0;
    REQ_MASK_EN = 1'b0; REQ_MASK_LEN = '0; RSP_READY = 1'b0;

    // Reset state
    #12;
    checkOutput("reset_rsp_valid", {31'b0, RSP_VALID}, 32'd0);
    checkOutput("reset_rsp_data", RSP_DATA, 32'd0);
    checkOutput("reset_busy", {31'b0, BUSY}, 32'd0);
    checkOutput("reset_step_sel", {30'b0, STEP_SEL}, 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    checkOutput("idle_req_ready", {31'b0, REQ_READY}, 32'd1);

    // RSP_READY held high while idle does nothing
    RSP_READY = 1'b1;
    repeat (3) @(negedge CLK);
    checkOutput("idle_rspready_busy", {31'b0, BUSY}, 32'd0);
    checkOutput("idle_rspready_valid", {31'b0, RSP_VALID}, 32'd0);
    RSP_READY = 1'b0;

    // Directed vector table
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].data, vecs[i].amt, vecs[i].dir, vecs[i].maskEn, vecs[i].maskLen,
                    0, gotData, gotLat, gotShifts, s0, s1, tmo);
      checkOutput($sformatf("vec%0d_timeout", i), {31'b0, tmo}, 32'd0);
      checkOutput($sformatf("vec%0d_data", i), gotData, vecs[i].expData);
      checkOutput($sformatf("vec%0d_latency", i), 32'(gotLat), 32'(vecs[i].expLat));
      if (i == 0) begin
        checkOutput("vec0_sel_first", {30'b0, s0}, 32'd3);
        checkOutput("vec0_sel_second", {30'b0, s1}, 32'd1);
        checkOutput("vec0_shift_cycles", 32'(gotShifts), 32'd2);
      end
      if (i == 1) checkOutput("vec1_shift_cycles", 32'(gotShifts), 32'd11);
      if (i == 3) checkOutput("vec3_shift_cycles", 32'(gotShifts), 32'd0);
    end

    // Backpressure: hold response 5 cycles while a second request waits
    @(negedge CLK);
    REQ_DATA = 32'h80000001; REQ_AMT = 5'd4; REQ_DIR = 1'b0;
    REQ_MASK_EN = 1'b0; REQ_MASK_LEN = 5'd0; REQ_VALID = 1'b1;
    @(posedge CLK);
    #1 REQ_DATA = 32'h0BADF00D; REQ_AMT = 5'd0;
    repeat (2) @(negedge CLK);
    stableOk = 1'b1;
    @(negedge CLK);
    checkOutput("bp_valid_reached", {31'b0, RSP_VALID}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      if (!(RSP_VALID === 1'b1 && RSP_DATA === 32'h00000018 && REQ_READY === 1'b0))
        stableOk = 1'b0;
      @(negedge CLK);
    end
    checkOutput("bp_hold_stable", {31'b0, stableOk}, 32'd1);
    RSP_READY = 1'b1;
    @(posedge CLK);
    #1 RSP_READY = 1'b0;
    @(negedge CLK);
    checkOutput("bp_second_ready", {31'b0, REQ_READY}, 32'd1);
    checkOutput("bp_valid_dropped", {31'b0, RSP_VALID}, 32'd0);
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
    @(negedge CLK);
    checkOutput("bp_second_valid", {31'b0, RSP_VALID}, 32'd1);
    checkOutput("bp_second_data", RSP_DATA, 32'h0BADF00D);
    RSP_READY = 1'b1;
    @(posedge CLK);
    #1 RSP_READY = 1'b0;

    // Reset in the middle of SHIFT
    @(negedge CLK);
    REQ_DATA = 32'h00000001; REQ_AMT = 5'd1; REQ_DIR = 1'b1;
    REQ_MASK_EN = 1'b0; REQ_VALID = 1'b1;
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("midshift_busy", {31'b0, BUSY}, 32'd1);
    #2 RESET_N = 1'b0;
    #1;
    checkOutput("midshift_rst_busy", {31'b0, BUSY}, 32'd0);
    checkOutput("midshift_rst_sel", {30'b0, STEP_SEL}, 32'd0);
    checkOutput("midshift_rst_data", RSP_DATA, 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    sawValid = 1'b0;
    readyOk = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge CLK);
      if (RSP_VALID !== 1'b0) sawValid = 1'b1;
      if (REQ_READY !== 1'b1) readyOk = 1'b0;
    end
    checkOutput("postrst_no_stale_rsp", {31'b0, sawValid}, 32'd0);
    checkOutput("postrst_ready", {31'b0, readyOk}, 32'd1);

    // Randomized operations against the reference model
    for (int n = 0; n < 40; n++) begin
      rd   = $urandom;
      ra   = 5'($urandom_range(0, 31));
      rdir = 1'($urandom_range(0, 1));
      rme  = 1'($urandom_range(0, 1));
      rml  = 5'($urandom_range(0, 31));
      e    = refEff(ra, rdir);
      applyStimulus(rd, ra, rdir, rme, rml, int'($urandom_range(0, 3)),
                    gotData, gotLat, gotShifts, s0, s1, tmo);
      checkOutput($sformatf("rand%0d_timeout", n), {31'b0, tmo}, 32'd0);
      checkOutput($sformatf("rand%0d_data", n), gotData, refResult(rd, ra, rdir, rme, rml));
      checkOutput($sformatf("rand%0d_latency", n), 32'(gotLat),
                  32'(1 + (e + 2) / 3 + int'(rme)));
      checkOutput($sformatf("rand%0d_shifts", n), 32'(gotShifts), 32'((e + 2) / 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/rot_sequencer.md
Name: rot_sequencer

Overview:
- Multi-cycle 32-bit rotate/field-extract engine for the microcode shift path.
- It builds an N-bit rotate from repeated 0–3-bit steps of a single 4-way select stage, using the same select coding as the 25S10-style shifter slices: 00 pass, 01 by 1, 10 by 2, 11 by 3.
- It can apply an optional low-order mask afterwards, as in an LDB-style byte extract.
- Requests and responses use a valid/ready handshake with the dispatch logic.

Parameters:
- WIDTH, 32, datapath width in bits; must be a power of two ≥ 4.
- AMT_W, 5, width of the rotate amount and mask length fields; equals log2(WIDTH).

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  block accepts a request this cycle.
- REQ_DATA  in  WIDTH  operand word.
- REQ_AMT  in  AMT_W  rotate amount, 0..WIDTH-1.
- REQ_DIR  in  1  0 = rotate left, 1 = rotate right.
- REQ_MASK_EN  in  1  apply the low-order mask after rotating.
- REQ_MASK_LEN  in  AMT_W  the mask keeps bits [REQ_MASK_LEN:0].
- RSP_VALID  out  1  result available.
- RSP_READY  in  1  consumer takes the result.
- RSP_DATA  out  WIDTH  result word.
- BUSY  out  1  high in every state except IDLE.
- STEP_SEL  out  2  select applied by the step stage this cycle (for the debug bus).

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - RSP_VALID=0, RSP_DATA=0, BUSY=0, STEP_SEL=00.
  - Internal data, count and mask registers are cleared.
  - Reset mid-operation discards the operation; no response is produced.
- Clock and reset: one clock domain, CLK. RESET_N is asynchronous, active-low.
- States: IDLE, SHIFT, MASK, DONE.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID&REQ_READY, capture data, mask_en and mask_len.
  - Effective left amount: E = REQ_AMT if REQ_DIR=0; E = (WIDTH-REQ_AMT) mod WIDTH if REQ_DIR=1.
  - Next state: if E≠0, go to SHIFT with remaining=E. Else if mask_en, go to MASK. Else go to DONE.
- SHIFT:
  - step = min(remaining,3); STEP_SEL=step.
  - data <= rotl(data, step); remaining <= remaining - step.
  - When remaining-step==0, go to MASK if mask_en, else DONE.
  - Cycle count is ceil(E/3), between 1 and 11 cycles.
  - STEP_SEL=00 in every state other than SHIFT.
- MASK: one cycle.
  - data <= data & ((2^(mask_len+1))-1).
  - mask_len=WIDTH-1 means all ones; the computation must not overflow.
  - Next state is DONE.
- DONE:
  - RSP_VALID=1 and RSP_DATA=data; both are held stable until RSP_READY.
  - On RSP_READY, go to IDLE with RSP_VALID=0 the next cycle.
  - No request is accepted in DONE; REQ_READY=0.
- Backpressure: REQ_READY=0 in SHIFT, MASK and DONE. The requester must hold its request.
- Latency, from the accepting edge to RSP_VALID:
  - 1 + ceil(E/3) + mask_en cycles.
  - E=0 with no mask gives RSP_VALID one cycle after accept.
- Boundary cases:
  - REQ_AMT=0 with either direction gives the same result as a pass.
  - A right rotate by 1 runs as a left rotate by 31, taking 11 SHIFT cycles.
  - RSP_READY held high while idle has no effect.
- All arithmetic is unsigned and modulo WIDTH.
- remaining is AMT_W bits wide and never underflows.

Decomposition:
- Shared package rot_pkg holds:
  - the state encoding: IDLE=2'd0, SHIFT=2'd1, MASK=2'd2, DONE=2'd3;
  - the step-select constants SEL_PASS/SEL_1/SEL_2/SEL_3;
  - a function for the effective amount.
- Sub-module rot_step (combinational): WIDTH-bit rotate-left by 0–3 under a 2-bit select. This is the word-wide equivalent of the shifter slice and is instantiated once.
- The FSM, counter and mask logic stay in rot_sequencer.

Test Plan:
- Left rotate, no mask:
  - Stimulus: DATA=0x80000001, AMT=4, DIR=0, MASK_EN=0.
  - Expect: STEP_SEL sequence 11,01; RSP_DATA=0x00000018; RSP_VALID 3 cycles after accept.
- Right rotate:
  - Stimulus: DATA=0x00000001, AMT=1, DIR=1.
  - Expect: 11 SHIFT cycles; RSP_DATA=0x80000000.
- Extract with mask:
  - Stimulus: DATA=0x12345678, AMT=24, DIR=1, MASK_EN=1, MASK_LEN=7.
  - Expect: RSP_DATA=0x00000012.
- Zero amount with full mask:
  - Stimulus: AMT=0, MASK_EN=1, MASK_LEN=31, DATA=0xDEADBEEF.
  - Expect: no SHIFT cycles; RSP_DATA=0xDEADBEEF; latency 2.
- Backpressure:
  - Stimulus: hold RSP_READY=0 for 5 cycles, and present a second request during DONE.
  - Expect: RSP_VALID and RSP_DATA stable; REQ_READY=0 throughout. After the handshake, the second request is accepted from IDLE.
- Reset mid-SHIFT:
  - Stimulus: assert RESET_N=0 asynchronously during SHIFT.
  - Expect: outputs go immediately to reset values; after release, IDLE with REQ_READY=1 and no stale response.
